io_mux_sequencer: RTL and testbench
===================================

IO_MUX_SEQUENCER -- requirements
Module: io_mux_sequencer

Interface
REQ-001 Parameter RXCOUNT, default 1, number of input functions of the downstream io_mux (>=1).
REQ-002 Parameter TXCOUNT, default 1, number of output functions of the downstream io_mux (>=1).
REQ-003 Parameter DEADTIME, default 4, cycles the pin is parked undriven when leaving an output function (>=1).
REQ-004 Parameter SYNC_STAGES, default 2, flip-flops in the pin input synchronizer (>=2).
REQ-005 Derived constants SHALL be FCOUNT=RXCOUNT+TXCOUNT and FWIDTH=$clog2(FCOUNT); selects 0..RXCOUNT-1 are inputs and RXCOUNT..FCOUNT-1 are outputs.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-008 req_valid  in  1  new function select offered.
REQ-009 req_ready  out  1  sequencer accepts a request this cycle.
REQ-010 req_select  in  FWIDTH  requested function index.
REQ-011 mux_select  out  FWIDTH  registered select driving io_mux func_select.
REQ-012 pin_in_raw  in  1  asynchronous physical pin level.
REQ-013 pin_in_sync  out  1  synchronized pin level driving io_mux pin_in.
REQ-014 busy  out  1  high while a switch sequence is in progress.
REQ-015 err_range  out  1  one-cycle pulse: request rejected, req_select>=FCOUNT.

Function
REQ-016 States SHALL be IDLE and DEAD; req_ready=1 and busy=0 exactly in IDLE.
REQ-017 A request is accepted on a rising edge with req_valid=1 and req_ready=1; otherwise req_select is ignored.
REQ-018 Accepted req_select>=FCOUNT: err_range=1 for the following cycle only, mux_select unchanged, remain IDLE.
REQ-019 Accepted req_select equal to mux_select: no change, remain IDLE, no error.
REQ-020 Accepted new select while mux_select<RXCOUNT (pin undriven): mux_select=req_select from the next cycle, remain IDLE (latency 1).
REQ-021 Accepted new select while mux_select>=RXCOUNT (pin driven): next cycle mux_select=0 (park, input function 0), target latched, down-counter loaded, enter DEAD.
REQ-022 In DEAD mux_select SHALL stay 0 for exactly DEADTIME cycles, then take the target value and return to IDLE (latency DEADTIME+1 from accept).
REQ-023 mux_select SHALL never pass through any value other than the old value, 0, and the target; no two different output functions in consecutive cycles.
REQ-024 req_valid during DEAD SHALL be ignored (req_ready=0); no queuing.
REQ-025 Counter width SHALL be $clog2(DEADTIME+1); counter wrap-around is impossible by construction.
REQ-026 pin_in_sync SHALL equal pin_in_raw delayed through SYNC_STAGES flip-flops (latency SYNC_STAGES cycles), independent of state.

Reset
REQ-027 rst_n low SHALL asynchronously force mux_select=0, state=IDLE, counter=0, err_range=0, all synchronizer flops=0.
REQ-028 Reset during DEAD SHALL abandon the pending target; after release the block is IDLE with mux_select=0.
REQ-029 First request SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-030 Package io_mux_pkg SHALL hold the state typedef (IDLE, DEAD) and the FWIDTH helper function shared with io_mux benches.
REQ-031 The synchronizer SHALL be a separate sub-module io_sync (parameter STAGES, ports clk, rst_n, d, q).
REQ-032 No other sub-modules; no latches; all outputs registered.

Verification (RXCOUNT=2, TXCOUNT=1, DEADTIME=3, SYNC_STAGES=2; selects 0,1 in, 2 out, 3 invalid)
REQ-033 Reset asserted then released -> mux_select=0, req_ready=1, busy=0, err_range=0, pin_in_sync=0.
REQ-034 From 0 request 2 -> mux_select=2 one cycle after accept, req_ready stays 1.
REQ-035 From 2 request 1 -> mux_select=0 for exactly 3 cycles with req_ready=0, busy=1, then mux_select=1; request 2 offered during DEAD is ignored.
REQ-036 Request 3 -> err_range high one cycle, mux_select unchanged; request equal to current -> no change.
REQ-037 rst_n low during the second DEAD cycle -> mux_select=0 immediately, no clock needed; after release IDLE, target 1 never appears.
REQ-038 pin_in_raw 0->1 between edges -> pin_in_sync rises on the 2nd following rising edge; io_mux instance connected downstream shows pin_ena=0 throughout every DEAD window.

Source files
------------

// File: rtl/io_mux_pkg.sv
// Shared types for the io_mux function-select sequencer and the benches that drive io_mux.
package io_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } seq_state_e;

  // Select width for a given number of mux functions; never narrower than one bit.
  function automatic int fwidth(input int fcount);
    return (fcount > 1) ? $clog2(fcount) : 1;
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchronizer bringing an asynchronous pin level into the clk domain.
module io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/io_mux_sequencer.sv
// Sequences io_mux function changes so a driven pin is parked undriven for DEADTIME
// cycles before any new function takes over; also synchronizes the pin input.
module io_mux_sequencer
  import io_mux_pkg::*;
#(
  parameter  int RXCOUNT     = 1,
  parameter  int TXCOUNT     = 1,
  parameter  int DEADTIME    = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int FCOUNT      = RXCOUNT + TXCOUNT,
  localparam int FWIDTH      = fwidth(FCOUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FWIDTH-1:0] req_select,
  output logic [FWIDTH-1:0] mux_select,
  input  logic              pin_in_raw,
  output logic              pin_in_sync,
  output logic              busy,
  output logic              err_range
);

  localparam int CW = $clog2(DEADTIME + 1);

  // One extra bit so FCOUNT itself is representable when it is a power of two.
  localparam logic [FWIDTH:0] FCOUNT_X  = FCOUNT[FWIDTH:0];
  localparam logic [FWIDTH:0] RXCOUNT_X = RXCOUNT[FWIDTH:0];
  localparam logic [CW-1:0]   DEAD_LOAD = CW'(DEADTIME);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(1);

  seq_state_e        state_q, state_d;
  logic [FWIDTH-1:0] mux_select_q, mux_select_d;
  logic [FWIDTH-1:0] target_q, target_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_range_q, err_range_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    mux_select_d = mux_select_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    err_range_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if ({1'b0, req_select} >= FCOUNT_X) begin
            err_range_d = 1'b1;
          end else if (req_select != mux_select_q) begin
            if ({1'b0, mux_select_q} < RXCOUNT_X) begin
              mux_select_d = req_select;
            end else begin
              // Leaving an output function: park on input 0 so the pin goes undriven first.
              mux_select_d = '0;
              target_d     = req_select;
              cnt_d        = DEAD_LOAD;
              state_d      = DEAD;
            end
          end
        end
      end
      DEAD: begin
        if (cnt_q == CNT_LAST) begin
          mux_select_d = target_q;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d == DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mux_select_q <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      err_range_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mux_select_q <= mux_select_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      err_range_q  <= err_range_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  io_sync #(
    .STAGES(SYNC_STAGES)
  ) u_io_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pin_in_raw),
    .q    (pin_in_sync)
  );

  assign mux_select = mux_select_q;
  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign err_range  = err_range_q;

endmodule

// File: tb/tb_io_mux_sequencer.sv
// Scoreboard bench for io_mux_sequencer with RXCOUNT=2, TXCOUNT=1, DEADTIME=3, SYNC_STAGES=2.
module tb_io_mux_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_select = 2'd0;
  logic [1:0] mux_select;
  logic       pin_in_raw = 1'b0;
  logic       pin_in_sync;
  logic       busy;
  logic       err_range;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int row;
    int mux;
    int rdy;
    int bsy;
    int err;
    int pin;
  } exp_t;

  exp_t exp_q[$];

  // Columns: valid, select, pin_raw | expected after the edge: mux, ready, busy, err, pin_sync
  int tab [27][8];

  io_mux_sequencer #(
    .RXCOUNT    (2),
    .TXCOUNT    (1),
    .DEADTIME   (3),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_select (req_select),
    .mux_select (mux_select),
    .pin_in_raw (pin_in_raw),
    .pin_in_sync(pin_in_sync),
    .busy       (busy),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected row per clock once stimulus has queued it.
  initial begin
    exp_t e;
    logic pin_ena;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && busy) begin
        pin_ena = (mux_select >= 2'd2);
        check("pin_ena_in_dead", int'(pin_ena), 0);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("row%0d_mux_select", e.row), int'(mux_select), e.mux);
        check($sformatf("row%0d_req_ready", e.row), int'(req_ready), e.rdy);
        check($sformatf("row%0d_busy", e.row), int'(busy), e.bsy);
        check($sformatf("row%0d_err_range", e.row), int'(err_range), e.err);
        check($sformatf("row%0d_pin_in_sync", e.row), int'(pin_in_sync), e.pin);
      end
    end
  end

  initial begin
    exp_t e;
    tab = '{
      '{1, 2, 0,  2, 1, 0, 0, 0},  // 0: from 0 request 2, direct
      '{0, 0, 0,  2, 1, 0, 0, 0},  // 1
      '{1, 1, 0,  0, 0, 1, 0, 0},  // 2: from 2 request 1, park
      '{1, 2, 0,  0, 0, 1, 0, 0},  // 3: ignored in DEAD
      '{1, 0, 0,  0, 0, 1, 0, 0},  // 4: ignored in DEAD
      '{0, 0, 0,  1, 1, 0, 0, 0},  // 5: target appears
      '{0, 0, 0,  1, 1, 0, 0, 0},  // 6
      '{1, 3, 0,  1, 1, 0, 1, 0},  // 7: out of range
      '{0, 0, 0,  1, 1, 0, 0, 0},  // 8
      '{1, 1, 0,  1, 1, 0, 0, 0},  // 9: same select
      '{1, 0, 0,  0, 1, 0, 0, 0},  // 10: input to input
      '{1, 2, 0,  2, 1, 0, 0, 0},  // 11
      '{0, 0, 1,  2, 1, 0, 0, 0},  // 12: pin rises between edges
      '{0, 0, 1,  2, 1, 0, 0, 1},  // 13
      '{1, 3, 1,  2, 1, 0, 1, 1},  // 14: out of range while driven
      '{1, 1, 1,  0, 0, 1, 0, 1},  // 15: park, first DEAD cycle
      '{0, 0, 1,  0, 0, 1, 0, 1},  // 16: second DEAD cycle, then reset
      '{0, 0, 1,  0, 1, 0, 0, 0},  // 17: after release
      '{0, 0, 1,  0, 1, 0, 0, 1},  // 18: abandoned target would show here
      '{0, 0, 0,  0, 1, 0, 0, 1},  // 19
      '{0, 0, 0,  0, 1, 0, 0, 0},  // 20
      '{1, 2, 0,  2, 1, 0, 0, 0},  // 21
      '{1, 0, 0,  0, 0, 1, 0, 0},  // 22: park toward input 0
      '{0, 0, 0,  0, 0, 1, 0, 0},  // 23
      '{0, 0, 0,  0, 0, 1, 0, 0},  // 24
      '{0, 0, 0,  0, 1, 0, 0, 0},  // 25
      '{1, 2, 0,  2, 1, 0, 0, 0}   // 26
    };

    #12;
    check("rst_mux_select", int'(mux_select), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err_range", int'(err_range), 0);
    check("rst_pin_in_sync", int'(pin_in_sync), 0);
    #8;
    rst_n = 1'b1;
    #2;
    check("rel_mux_select", int'(mux_select), 0);
    check("rel_req_ready", int'(req_ready), 1);

    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #2;
      if (i == 17) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_mux_select", int'(mux_select), 0);
        check("midreset_req_ready", int'(req_ready), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_pin_in_sync", int'(pin_in_sync), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
      req_valid  = tab[i][0][0];
      req_select = 2'(tab[i][1]);
      pin_in_raw = tab[i][2][0];
      e.row = i;
      e.mux = tab[i][3];
      e.rdy = tab[i][4];
      e.bsy = tab[i][5];
      e.err = tab[i][6];
      e.pin = tab[i][7];
      exp_q.push_back(e);
    end

    @(posedge clk);
    #2;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      @(posedge clk);
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
